if_axi_responder: RTL and testbench
===================================

// Module: if_axi_responder
// PURPOSE
//  Responder for the CPU instruction-fetch handshake (valid/addr/size -> ready/data/resp).
//  Converts each fetch request into one single-beat AXI4 read (AR + R channels).
//  Returns the beat to the fetch stage as a one-cycle ready pulse carrying data and resp.
//  Sits between the core's fetch port and the AXI interconnect in the top-level SoC wrapper.
// PARAMETERS
//  ID_W     4    AXI ID width
//  AXI_ID   0    ID driven on ar_id and expected on r_id
//  TIMEOUT  256  max cycles waiting in S_AR+S_R before error response; 0 disables
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous reset, active low
//  if_valid      in   1     fetch request; held until if_ready pulse
//  if_addr       in   64    fetch byte address
//  if_size       in   2     00 byte, 01 half, 10 word, 11 dword
//  if_ready      out  1     one-cycle completion pulse
//  if_data_read  out  64    read data, valid only while if_ready=1
//  if_resp       out  2     AXI-style resp (00 OKAY, 10 SLVERR), valid while if_ready=1
//  ar_valid      out  1     AXI read address valid
//  ar_ready      in   1     AXI read address ready
//  ar_addr       out  64    = latched if_addr
//  ar_id         out  ID_W  = AXI_ID
//  ar_len        out  8     constant 0 (single beat)
//  ar_size       out  3     = {1'b0, latched if_size}
//  ar_burst      out  2     constant 2'b01 (INCR)
//  r_valid       in   1     AXI read data valid
//  r_ready       out  1     AXI read data ready
//  r_data        in   64    AXI read data (8-byte aligned beat)
//  r_resp        in   2     AXI read response
//  r_last        in   1     last beat
//  r_id          in   ID_W  read ID
// BEHAVIOUR
//  Reset (rst=0, async): state S_IDLE; if_ready, ar_valid, r_ready, if_data_read, if_resp,
//   ar_addr, timeout counter all 0. Outstanding AXI transaction abandoned (bus resets together).
//  FSM, all outputs registered:
//  - S_IDLE: if_valid=1 -> latch addr/size, ar_valid<=1, -> S_AR. Any if_valid seen here is a
//    new request (requester drops/changes valid the cycle after the ready pulse).
//  - S_AR: ar_valid=1 held, ar_addr/ar_size stable; on ar_valid&&ar_ready -> ar_valid<=0,
//    r_ready<=1, -> S_R.
//  - S_R: on r_valid&&r_ready: first beat captured (data, resp); beats after the first are
//    consumed and discarded. On the beat with r_last=1 -> r_ready<=0, -> S_RESP.
//  - S_RESP: if_ready=1 for exactly one cycle with data/resp; -> S_IDLE.
//  Data alignment: if_data_read = r_data >> (8*addr[2:0]); upper bits above size zero-filled.
//  Resp: r_resp of captured beat; forced 2'b10 if r_id != AXI_ID on that beat.
//  Timeout: counter clears on entering S_AR, increments each cycle in S_AR/S_R; on reaching
//   TIMEOUT -> drop ar_valid/r_ready, if_data_read=0, if_resp=2'b10, -> S_RESP.
//   Late R beats after timeout ignored (r_ready=0 outside S_R).
//  Latency: ar_ready and r_valid both 1 immediately -> if_ready 3 cycles after if_valid
//   first sampled in S_IDLE. One request outstanding; no pipelining.
//  if_valid dropping mid-transaction is ignored; transaction completes and pulses if_ready.
//  Simultaneous r_valid with r_last=0 then r_last=1: data from first beat returned.
// TESTING
//  1. addr=0x8000_0000, size=10, ar_ready=1, r_data=0x1111_2222_0000_0013 next cycle
//     -> ar_addr=0x8000_0000, ar_size=3'b010; if_ready at cycle 3, data=0x0000_0013, resp=00.
//  2. addr=0x8000_0004, size=10, r_data=0xDEAD_BEEF_0000_0000 -> data=0xDEAD_BEEF.
//  3. ar_ready held 0 for 5 cycles, r_valid 4 cycles late -> ar_valid/ar_addr stable
//     throughout; exactly one if_ready pulse, resp=00.
//  4. TIMEOUT=8, no ar_ready -> if_ready at 8 cycles after S_AR entry, resp=10, data=0.
//  5. r_resp=10 or r_id=5 with AXI_ID=0 -> if_resp=10.
//  6. rst=0 asynchronously while in S_R -> all outputs 0 immediately; new request after
//     release completes normally.

Source files
------------

// File: rtl/if_axi_responder.sv
// Instruction-fetch responder: turns each fetch request into one single-beat AXI4 read
// and returns the aligned beat as a one-cycle if_ready pulse with data and resp.
module if_axi_responder #(
  parameter int ID_W    = 4,
  parameter int AXI_ID  = 0,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [63:0]     if_addr,
  input  logic [1:0]      if_size,
  output logic            if_ready,
  output logic [63:0]     if_data_read,
  output logic [1:0]      if_resp,
  output logic            ar_valid,
  input  logic            ar_ready,
  output logic [63:0]     ar_addr,
  output logic [ID_W-1:0] ar_id,
  output logic [7:0]      ar_len,
  output logic [2:0]      ar_size,
  output logic [1:0]      ar_burst,
  input  logic            r_valid,
  output logic            r_ready,
  input  logic [63:0]     r_data,
  input  logic [1:0]      r_resp,
  input  logic            r_last,
  input  logic [ID_W-1:0] r_id,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int                CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_LIMIT    = CNT_W'(TIMEOUT);
  localparam logic [ID_W-1:0]   ID_VAL      = ID_W'(AXI_ID);
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  state_t           state, state_n;
  logic [1:0]       size_q, size_n;
  logic [63:0]      addr_n;
  logic             ar_valid_n, r_ready_n, if_ready_n;
  logic [63:0]      data_n;
  logic [1:0]       resp_n;
  logic [63:0]      cap_data, cap_data_n;
  logic [1:0]       cap_resp, cap_resp_n;
  logic             got_beat, got_beat_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             timed_out;
  logic [63:0]      size_mask;
  logic [63:0]      beat_data;
  logic [1:0]       beat_resp;

  // A transfer happens on any channel only in a cycle where both valid and ready are high;
  // our valid/ready outputs are registered and held until that cycle.
  assign ar_id     = ID_VAL;
  assign ar_len    = 8'd0;
  assign ar_burst  = 2'b01;
  assign ar_size   = {1'b0, size_q};
  assign fsm_state = state;

  always_comb begin
    size_mask = '1;
    case (size_q)
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
  end

  // The beat is 8-byte aligned; bring the addressed byte down to bit 0.
  assign beat_data = (r_data >> {ar_addr[2:0], 3'b000}) & size_mask;
  assign beat_resp = (r_id != ID_VAL) ? RESP_SLVERR : r_resp;

  assign cnt_inc   = cnt + 1'b1;
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == TO_LIMIT);

  always_comb begin
    state_n    = state;
    size_n     = size_q;
    addr_n     = ar_addr;
    ar_valid_n = ar_valid;
    r_ready_n  = r_ready;
    if_ready_n = 1'b0;
    data_n     = if_data_read;
    resp_n     = if_resp;
    cap_data_n = cap_data;
    cap_resp_n = cap_resp;
    got_beat_n = got_beat;
    cnt_n      = cnt;
    case (state)
      S_IDLE: begin
        if (if_valid) begin
          state_n    = S_AR;
          addr_n     = if_addr;
          size_n     = if_size;
          ar_valid_n = 1'b1;
          cnt_n      = '0;
          got_beat_n = 1'b0;
        end
      end
      S_AR: begin
        if (TIMEOUT != 0) cnt_n = cnt_inc;
        if (timed_out) begin
          ar_valid_n = 1'b0;
          if_ready_n = 1'b1;
          data_n     = '0;
          resp_n     = RESP_SLVERR;
          state_n    = S_RESP;
        end else if (ar_valid && ar_ready) begin
          ar_valid_n = 1'b0;
          r_ready_n  = 1'b1;
          state_n    = S_R;
        end
      end
      S_R: begin
        if (TIMEOUT != 0) cnt_n = cnt_inc;
        if (timed_out) begin
          r_ready_n  = 1'b0;
          if_ready_n = 1'b1;
          data_n     = '0;
          resp_n     = RESP_SLVERR;
          state_n    = S_RESP;
        end else if (r_valid && r_ready) begin
          // Only the first beat of a (misbehaving) multi-beat reply is returned.
          if (!got_beat) begin
            cap_data_n = beat_data;
            cap_resp_n = beat_resp;
          end
          got_beat_n = 1'b1;
          if (r_last) begin
            r_ready_n  = 1'b0;
            if_ready_n = 1'b1;
            data_n     = got_beat ? cap_data : beat_data;
            resp_n     = got_beat ? cap_resp : beat_resp;
            state_n    = S_RESP;
          end
        end
      end
      S_RESP: begin
        data_n  = '0;
        resp_n  = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      size_q       <= '0;
      ar_addr      <= '0;
      ar_valid     <= 1'b0;
      r_ready      <= 1'b0;
      if_ready     <= 1'b0;
      if_data_read <= '0;
      if_resp      <= '0;
      cap_data     <= '0;
      cap_resp     <= '0;
      got_beat     <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_n;
      size_q       <= size_n;
      ar_addr      <= addr_n;
      ar_valid     <= ar_valid_n;
      r_ready      <= r_ready_n;
      if_ready     <= if_ready_n;
      if_data_read <= data_n;
      if_resp      <= resp_n;
      cap_data     <= cap_data_n;
      cap_resp     <= cap_resp_n;
      got_beat     <= got_beat_n;
      cnt          <= cnt_n;
    end
  end

endmodule

// File: tb/tb_if_axi_responder.sv
// Directed bench for if_axi_responder: a default-timeout instance for data/latency/error
// paths and a TIMEOUT=8 instance for the timeout path.
module tb_if_axi_responder;
  localparam int ID_W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main instance
  logic            if_valid, if_ready, ar_valid, ar_ready, r_ready, r_valid, r_last;
  logic [63:0]     if_addr, if_data_read, ar_addr, r_data;
  logic [1:0]      if_size, if_resp, ar_burst, r_resp, fsm_state;
  logic [ID_W-1:0] ar_id, r_id;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;

  // timeout instance
  logic            t_valid, t_if_ready, t_ar_valid, t_ar_ready, t_r_ready, t_r_valid, t_r_last;
  logic [63:0]     t_addr, t_data, t_ar_addr, t_r_data;
  logic [1:0]      t_size, t_resp, t_ar_burst, t_r_resp, t_state;
  logic [ID_W-1:0] t_ar_id, t_r_id;
  logic [7:0]      t_ar_len;
  logic [2:0]      t_ar_size;

  if_axi_responder #(.ID_W(ID_W), .AXI_ID(0), .TIMEOUT(256)) u_dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
    .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id), .fsm_state(fsm_state)
  );

  if_axi_responder #(.ID_W(ID_W), .AXI_ID(0), .TIMEOUT(8)) u_to (
    .clk(clk), .rst(rst),
    .if_valid(t_valid), .if_addr(t_addr), .if_size(t_size),
    .if_ready(t_if_ready), .if_data_read(t_data), .if_resp(t_resp),
    .ar_valid(t_ar_valid), .ar_ready(t_ar_ready), .ar_addr(t_ar_addr), .ar_id(t_ar_id),
    .ar_len(t_ar_len), .ar_size(t_ar_size), .ar_burst(t_ar_burst),
    .r_valid(t_r_valid), .r_ready(t_r_ready), .r_data(t_r_data), .r_resp(t_r_resp),
    .r_last(t_r_last), .r_id(t_r_id), .fsm_state(t_state)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_fetch  = 0;
  int          pulse_cnt = 0;
  logic [65:0] exp_q[$];
  logic [65:0] sb_e;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every if_ready pulse of the main instance consumes one expected {resp,data}
  always @(negedge clk) begin
    if (rst && if_ready) begin
      pulse_cnt++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected: observed if_ready pulse, expected none pending");
      end
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        chk("sb_resp_data", {if_resp, if_data_read}, sb_e);
      end
    end
  end

  // driver: one fetch with configurable AR/R stalls, optional extra leading beat
  task automatic do_fetch(input logic [63:0] addr, input logic [1:0] size,
                          input logic [63:0] d0, input logic [1:0] rr, input logic [ID_W-1:0] rid,
                          input int ar_dly, input int r_dly, input bit two_beats,
                          input bit drop_valid, input logic [63:0] exp_data,
                          input logic [1:0] exp_resp);
    n_fetch++;
    exp_q.push_back({exp_resp, exp_data});
    if_valid = 1'b1; if_addr = addr; if_size = size;
    @(negedge clk);
    chk("ar_valid_set", 66'(ar_valid), 66'd1);
    chk("ar_addr", 66'(ar_addr), 66'(addr));
    chk("ar_size", 66'(ar_size), 66'({1'b0, size}));
    if (drop_valid) begin
      if_valid = 1'b0; if_addr = '1; if_size = 2'b11;
    end
    for (int i = 0; i < ar_dly; i++) begin
      @(negedge clk);
      chk("ar_hold_valid", 66'(ar_valid), 66'd1);
      chk("ar_hold_addr", 66'(ar_addr), 66'(addr));
    end
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    chk("ar_valid_drop", 66'(ar_valid), 66'd0);
    chk("r_ready_set", 66'(r_ready), 66'd1);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("r_ready_hold", 66'({r_ready, if_ready}), 66'd2);
    end
    r_valid = 1'b1; r_data = d0; r_resp = rr; r_id = rid; r_last = !two_beats;
    if (two_beats) begin
      @(negedge clk);
      chk("r_ready_mid", 66'({r_ready, if_ready}), 66'd2);
      r_data = ~d0; r_resp = 2'b10; r_last = 1'b1;
    end
    @(negedge clk);
    r_valid = 1'b0; r_last = 1'b0; r_data = '0; r_resp = '0; r_id = '0;
    chk("if_ready_pulse", 66'(if_ready), 66'd1);
    chk("r_ready_drop", 66'(r_ready), 66'd0);
    if_valid = 1'b0;
    @(negedge clk);
    chk("if_ready_one_cycle", 66'(if_ready), 66'd0);
    chk("back_idle", 66'(fsm_state), 66'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rd;
    rst = 1'b0;
    if_valid = 0; if_addr = '0; if_size = '0; ar_ready = 0;
    r_valid = 0; r_data = '0; r_resp = '0; r_last = 0; r_id = '0;
    t_valid = 0; t_addr = '0; t_size = '0; t_ar_ready = 0;
    t_r_valid = 0; t_r_data = 64'h5555_5555_5555_5555; t_r_resp = '0; t_r_last = 0; t_r_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 66'({if_ready, ar_valid, r_ready, if_resp, fsm_state}), 66'd0);
    chk("rst_data", 66'(if_data_read), 66'd0);
    chk("rst_addr", 66'(ar_addr), 66'd0);
    chk("ar_const", 66'({ar_id, ar_len, ar_burst}), 66'({4'd0, 8'd0, 2'b01}));
    rst = 1'b1;
    @(negedge clk);

    // directed fetches
    do_fetch(64'h8000_0000, 2'b10, 64'h1111_2222_0000_0013, 2'b00, 4'd0, 0, 0, 0, 0,
             64'h0000_0013, 2'b00);
    do_fetch(64'h8000_0004, 2'b10, 64'hDEAD_BEEF_0000_0000, 2'b00, 4'd0, 0, 0, 0, 0,
             64'hDEAD_BEEF, 2'b00);
    do_fetch(64'h8000_0010, 2'b11, 64'h0123_4567_89AB_CDEF, 2'b00, 4'd0, 5, 4, 0, 0,
             64'h0123_4567_89AB_CDEF, 2'b00);
    do_fetch(64'h0000_0002, 2'b00, 64'h0000_0000_00AA_BBCC, 2'b10, 4'd0, 1, 0, 0, 0,
             64'h0000_00AA, 2'b10);
    do_fetch(64'h0000_0006, 2'b01, 64'h1234_5678_9ABC_DEF0, 2'b00, 4'd5, 0, 2, 0, 0,
             64'h0000_1234, 2'b10);
    do_fetch(64'h8000_0100, 2'b00, 64'h0000_0000_0000_00A5, 2'b00, 4'd0, 0, 1, 1, 1,
             64'h0000_00A5, 2'b00);
    do_fetch(64'h0000_0007, 2'b00, 64'h7700_0000_0000_0000, 2'b00, 4'd0, 2, 0, 0, 0,
             64'h0000_0077, 2'b00);
    do_fetch(64'h0000_0010, 2'b01, 64'hFFFF_FFFF_FFFF_1234, 2'b00, 4'd0, 0, 0, 0, 0,
             64'h0000_1234, 2'b00);

    // random aligned dword fetches with random stalls
    for (int k = 0; k < 4; k++) begin
      ra = {$urandom, $urandom} & ~64'h7;
      rd = {$urandom, $urandom};
      do_fetch(ra, 2'b11, rd, 2'b00, 4'd0, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0,
               rd, 2'b00);
    end

    // timeout instance: AR never accepted
    t_valid = 1'b1; t_addr = 64'h0000_1000; t_size = 2'b11;
    @(negedge clk);
    chk("to_ar_valid", 66'(t_ar_valid), 66'd1);
    chk("to_ar_fields", 66'({t_ar_addr, t_ar_size}), 66'({64'h0000_1000, 3'b011}));
    chk("to_ar_const", 66'({t_ar_id, t_ar_len, t_ar_burst}), 66'({4'd0, 8'd0, 2'b01}));
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("to_waiting", 66'({t_if_ready, t_ar_valid}), 66'd1);
    end
    @(negedge clk);
    t_valid = 1'b0;
    chk("to_if_ready", 66'(t_if_ready), 66'd1);
    chk("to_resp_data", {t_resp, t_data}, {2'b10, 64'd0});
    chk("to_bus_drop", 66'({t_ar_valid, t_r_ready}), 66'd0);
    t_r_valid = 1'b1; t_r_last = 1'b1;
    @(negedge clk);
    chk("to_late_beat", 66'({t_if_ready, t_r_ready, t_state}), 66'd0);
    t_r_valid = 1'b0; t_r_last = 1'b0;

    // asynchronous reset while waiting in S_R
    if_valid = 1'b1; if_addr = 64'h4000_0008; if_size = 2'b11;
    @(negedge clk);
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0; if_valid = 1'b0;
    chk("pre_reset_in_r", 66'({fsm_state, r_ready}), 66'({2'd2, 1'b1}));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctrl", 66'({if_ready, ar_valid, r_ready, if_resp, fsm_state}), 66'd0);
    chk("async_rst_addr", 66'(ar_addr), 66'd0);
    chk("async_rst_data", 66'(if_data_read), 66'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_fetch(64'h4000_0008, 2'b10, 64'h0000_0000_CAFE_F00D, 2'b00, 4'd0, 0, 0, 0, 0,
             64'hCAFE_F00D, 2'b00);

    repeat (2) @(negedge clk);
    chk("sb_drained", 66'(exp_q.size()), 66'd0);
    chk("pulse_count", 66'(pulse_cnt), 66'(n_fetch));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
